membus_arbiter: RTL and testbench
=================================

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 Parameter TA_CYCLES, default 1: idle turnaround cycles between CMD and first read byte; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req[1:0]  input  2  per-requester transfer request; 0 = CPU, 1 = debug/DMA.
REQ-005 addr0, addr1  input  32 each  transfer address; held stable while the matching req is high.
REQ-006 wdata0, wdata1  input  32 each  write data; held stable while the matching req is high.
REQ-007 we[1:0]  input  2  1 = write, 0 = read; held stable while the matching req is high.
REQ-008 ack[1:0]  output  2  one-cycle completion pulse per requester.
REQ-009 rdata  output  32  read result; valid in the ack cycle, held until the next read completes.
REQ-010 ext_out  output  8  byte lane to pins (address bytes, then command byte).
REQ-011 ext_wd  output  8  write-data byte lane to bidirectional pins.
REQ-012 ext_oe  output  8  output enable for the bidirectional pins; 1 = drive.
REQ-013 ext_in  input  8  read-data byte lane from bidirectional pins.
REQ-014 frame  output  1  high from first ADDR cycle through last READ/CMD cycle.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, ADDR, CMD, TURN, READ, RESP; a 2-bit byte index counts within ADDR and READ.
REQ-017 IDLE: with any req high, latch the winner's addr/wdata/we and grant id, then go to ADDR with index 0 on the next edge.
REQ-018 Arbitration is round-robin: a single request wins; on simultaneous requests, the requester not granted last wins; after reset, requester 0 has priority.
REQ-019 ADDR, index n (0..3): ext_out = addr[8n+7:8n]; ext_wd = wdata[8n+7:8n] for writes, else 0; ext_oe = 8'hFF for writes, else 8'h00; after index 3, go to CMD.
REQ-020 CMD: ext_out = {6'b0, grant_id, we}; ext_oe as in ADDR, ext_wd = 0; a write goes to RESP, a read goes to TURN.
REQ-021 TURN: lasts exactly TA_CYCLES cycles with ext_oe = 0, ext_out = 0, then go to READ with index 0.
REQ-022 READ, index n: capture ext_in into rdata[8n+7:8n] on the edge ending the cycle; ext_oe = 0; after index 3, go to RESP.
REQ-023 RESP: assert ack[grant_id] for exactly one cycle and record grant_id as last-granted; next state is IDLE; ext_out = 0, frame = 0.
REQ-024 Latency, counted from the IDLE sample edge to the ack cycle: 6 cycles for a write and 6 + TA_CYCLES + 4 cycles for a read.
REQ-025 Back-to-back: a req still high in the IDLE cycle after RESP starts a new transfer; requesters must drop req in the ack cycle to avoid a repeat.
REQ-026 A req deasserted mid-transfer is ignored; the transfer completes and ack still pulses.
REQ-027 A new req arriving during a transfer waits; at most one transfer is in flight.
REQ-028 In IDLE, ext_out = 0, ext_wd = 0, ext_oe = 0, frame = 0, busy = 0.
REQ-029 rdata is updated only by reads; writes leave it unchanged.

Reset
REQ-030 On rst_n low, immediately: state IDLE, index 0, ack = 0, rdata = 0, all ext_* outputs 0, frame = 0, busy = 0, last-granted = 1.
REQ-031 Reset mid-transfer aborts the transfer with no ack.
REQ-032 After reset, the first edge with rst_n high may grant.

Structure
REQ-033 Package membus_pkg holds the state enum, command-byte field positions, and the OE_DRIVE/OE_FLOAT constants.
REQ-034 Arbitration lives in sub-module rr_arb2 (req[1:0], last-granted in -> grant one-hot, purely combinational); the FSM and datapath stay in membus_arbiter.

Verification
REQ-035 Write: req0, addr0 = 32'h12345678, wdata0 = 32'hAABBCCDD, we0 = 1 -> ext_out 78,56,34,12,01; ext_wd DD,CC,BB,AA; ext_oe FF for 5 cycles; ack[0] on cycle 6.
REQ-036 Read: req1, addr1 = 32'h00000010, we1 = 0, pins supply 11,22,33,44 -> CMD 8'h02; TURN 1 cycle with oe 00; rdata = 32'h44332211 with ack[1] on cycle 11.
REQ-037 Contention: req = 2'b11 held through 4 transfers -> grant order 0,1,0,1, each ack a single cycle.
REQ-038 Abort: rst_n low during READ index 2 -> all outputs 0 at once, no ack; the next read returns correct data.
REQ-039 Drop req: req0 falls during ADDR index 1 -> the transfer still completes and ack[0] pulses once.
REQ-040 TA_CYCLES = 3 -> read ack on cycle 13; ext_oe = 0 for every TURN and READ cycle.

Source files
------------

// File: rtl/membus_pkg.sv
// Shared types and constants for the byte-serial memory bus arbiter.
// Holds the FSM encoding, command-byte layout and pin-drive constants.
package membus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_CMD  = 3'd2,
        ST_TURN = 3'd3,
        ST_READ = 3'd4,
        ST_RESP = 3'd5
    } state_e;

    localparam int CMD_WE_POS = 0;
    localparam int CMD_ID_POS = 1;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_FLOAT = 8'h00;

    function automatic logic [7:0] cmd_byte(input logic id, input logic we);
        logic [7:0] b;
        b = 8'h00;
        b[CMD_ID_POS] = id;
        b[CMD_WE_POS] = we;
        return b;
    endfunction

endpackage

// File: rtl/membus_arbiter_arb.sv
// Two-way round-robin arbiter, purely combinational.
// On contention the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/membus_arbiter.sv
// Arbitrates two requesters onto an 8-bit serial memory bus:
// four address bytes, a command byte, optional turnaround and read bytes.
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int TA_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [1:0]  we,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic [7:0]  ext_out,
    output logic [7:0]  ext_wd,
    output logic [7:0]  ext_oe,
    input  logic [7:0]  ext_in,
    output logic        frame,
    output logic        busy
);

    localparam logic [2:0] TA_LAST = 3'(TA_CYCLES - 1);

    state_e      r_state;
    logic [1:0]  r_idx;
    logic [2:0]  r_ta;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_gid;
    logic        r_last;
    logic [31:0] r_rdata;

    logic [1:0]  w_gnt;
    logic [4:0]  w_bit;

    rr_arb2 u_arb (
        .req  (req),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign w_bit = {r_idx, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_ta    <= 3'd0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_we    <= 1'b0;
            r_gid   <= 1'b0;
            r_last  <= 1'b1;
            r_rdata <= 32'h0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gid   <= w_gnt[1];
                        r_addr  <= w_gnt[1] ? addr1 : addr0;
                        r_wdata <= w_gnt[1] ? wdata1 : wdata0;
                        r_we    <= w_gnt[1] ? we[1] : we[0];
                        r_idx   <= 2'd0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3)
                        r_state <= ST_CMD;
                end
                ST_CMD: begin
                    r_ta <= 3'd0;
                    r_state <= r_we ? ST_RESP : ST_TURN;
                end
                ST_TURN: begin
                    r_ta <= r_ta + 3'd1;
                    if (r_ta == TA_LAST) begin
                        r_idx   <= 2'd0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_rdata[w_bit +: 8] <= ext_in;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3)
                        r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_last  <= r_gid;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Pin outputs are decoded from registered state only.
    always_comb begin
        ack     = 2'b00;
        ext_out = 8'h00;
        ext_wd  = 8'h00;
        ext_oe  = OE_FLOAT;
        frame   = 1'b0;
        unique case (r_state)
            ST_ADDR: begin
                ext_out = r_addr[w_bit +: 8];
                ext_wd  = r_we ? r_wdata[w_bit +: 8] : 8'h00;
                ext_oe  = r_we ? OE_DRIVE : OE_FLOAT;
                frame   = 1'b1;
            end
            ST_CMD: begin
                ext_out = cmd_byte(r_gid, r_we);
                ext_oe  = r_we ? OE_DRIVE : OE_FLOAT;
                frame   = 1'b1;
            end
            ST_TURN: frame = 1'b1;
            ST_READ: frame = 1'b1;
            ST_RESP: ack = r_gid ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    assign busy  = (r_state != ST_IDLE);
    assign rdata = r_rdata;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: writes, reads, contention,
// dropped request, mid-read reset and a longer turnaround instance.
module tb_membus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, req3;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  we;
    logic [7:0]  ext_in;

    logic [1:0]  ack1, ack3;
    logic [31:0] rdata1, rdata3;
    logic [7:0]  out1, out3, wd1, wd3, oe1, oe3;
    logic        frame1, frame3, busy1, busy3;

    logic        d3;
    logic [1:0]  m_ack;
    logic [31:0] m_rdata;
    logic [7:0]  m_out, m_wd, m_oe;
    logic        m_frame, m_busy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    membus_arbiter #(.TA_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we(we),
        .ack(ack1), .rdata(rdata1),
        .ext_out(out1), .ext_wd(wd1), .ext_oe(oe1),
        .ext_in(ext_in), .frame(frame1), .busy(busy1)
    );

    membus_arbiter #(.TA_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we(we),
        .ack(ack3), .rdata(rdata3),
        .ext_out(out3), .ext_wd(wd3), .ext_oe(oe3),
        .ext_in(ext_in), .frame(frame3), .busy(busy3)
    );

    assign m_ack   = d3 ? ack3   : ack1;
    assign m_rdata = d3 ? rdata3 : rdata1;
    assign m_out   = d3 ? out3   : out1;
    assign m_wd    = d3 ? wd3    : wd1;
    assign m_oe    = d3 ? oe3    : oe1;
    assign m_frame = d3 ? frame3 : frame1;
    assign m_busy  = d3 ? busy3  : busy1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_ack", m_ack, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_frame", m_frame, 0);
        chk("rst_out", m_out, 0);
        chk("rst_wd", m_wd, 0);
        chk("rst_oe", m_oe, 0);
        chk("rst_rdata", m_rdata, 0);
    endtask

    task automatic xfer(input bit t3, input bit id, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int drop_at,
                        input int abort_at, input bit hold);
        int ta;
        int lc;
        logic [1:0] oh;
        logic [7:0] oe;
        ta = t3 ? 3 : 1;
        lc = wr ? 6 : 10 + ta;
        oh = id ? 2'b10 : 2'b01;
        oe = wr ? 8'hFF : 8'h00;
        d3 = t3;
        if (id) begin
            addr1 = a; wdata1 = wd; we[1] = wr;
        end else begin
            addr0 = a; wdata0 = wd; we[0] = wr;
        end
        if (t3) req3[id] = 1'b1;
        else    req[id]  = 1'b1;
        for (int c = 1; c <= lc; c++) begin
            tick();
            chk("ack", m_ack, (c == lc) ? oh : 2'b00);
            chk("busy", m_busy, 1);
            if (c <= 4) begin
                int s;
                s = 8 * (c - 1);
                chk("addr_byte", m_out, a[s +: 8]);
                chk("wd_byte", m_wd, wr ? wd[s +: 8] : 8'h00);
                chk("addr_oe", m_oe, oe);
                chk("addr_frame", m_frame, 1);
            end else if (c == 5) begin
                chk("cmd_byte", m_out, {6'b0, id, wr});
                chk("cmd_oe", m_oe, oe);
                chk("cmd_wd", m_wd, 0);
            end else if (c < lc) begin
                chk("turn_read_oe", m_oe, 0);
                chk("turn_read_out", m_out, 0);
                chk("turn_read_frame", m_frame, 1);
                if (c >= 6 + ta) begin
                    int k;
                    k = 8 * (c - 6 - ta);
                    ext_in = rd[k +: 8];
                end
            end
            if (c == drop_at) begin
                if (t3) req3[id] = 1'b0;
                else    req[id]  = 1'b0;
            end
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outs();
                return;
            end
            if (c == lc) begin
                chk("resp_frame", m_frame, 0);
                chk("resp_out", m_out, 0);
                if (!wr) exp_rd[t3] = rd;
                chk("rdata", m_rdata, exp_rd[t3]);
                if (!hold) begin
                    req  = 2'b00;
                    req3 = 2'b00;
                end
            end
        end
        tick();
        chk("idle_busy", m_busy, 0);
        chk("idle_ack", m_ack, 0);
        chk("idle_oe", m_oe, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00; req3 = 2'b00;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        we = 2'b00; ext_in = 8'h00;
        d3 = 1'b0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        repeat (3) tick();
        chk_reset_outs();
        d3 = 1'b1;
        chk_reset_outs();
        rst_n = 1'b1;

        xfer(0, 0, 1, 32'h12345678, 32'hAABBCCDD, 0, 0, 0, 0);
        xfer(0, 1, 0, 32'h00000010, 0, 32'h44332211, 0, 0, 0);

        addr0 = 32'hA0A0A0A0; addr1 = 32'hB1B1B1B1;
        wdata0 = 32'h01020304; wdata1 = 32'h05060708;
        we = 2'b11; req = 2'b11;
        xfer(0, 0, 1, 32'hA0A0A0A0, 32'h01020304, 0, 0, 0, 1);
        xfer(0, 1, 1, 32'hB1B1B1B1, 32'h05060708, 0, 0, 0, 1);
        xfer(0, 0, 1, 32'hA0A0A0A0, 32'h01020304, 0, 0, 0, 1);
        xfer(0, 1, 1, 32'hB1B1B1B1, 32'h05060708, 0, 0, 0, 0);

        xfer(0, 0, 1, 32'hCAFEF00D, 32'h9ABCDEF0, 0, 2, 0, 0);

        xfer(0, 1, 0, 32'h00000020, 0, 32'h87654321, 0, 9, 0);
        repeat (2) tick();
        req = 2'b00; req3 = 2'b00; ext_in = 8'h00;
        exp_rd[0] = 0; exp_rd[1] = 0;
        rst_n = 1'b1;
        xfer(0, 0, 0, 32'h00000030, 0, 32'hDEADBEEF, 0, 0, 0);

        xfer(1, 1, 0, 32'h00000040, 0, 32'h5A6B7C8D, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
